// File: rtl/irq_io_bridge.sv
// Memory-mapped I/O bridge: decodes CPU data accesses into device windows and a
// local block holding interrupt pending/mask registers and a bus-error logger.
module irq_io_bridge #(
  parameter int unsigned     NDEV      = 2,
  parameter logic [31:0]     BASE      = 32'h0000_7f00,
  parameter logic [31:0]     STRIDE    = 32'h10,
  parameter int unsigned     WIN_BYTES = 12,
  parameter logic [NDEV-1:0] IRQ_EDGE  = {NDEV{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cpu_addr,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [3:0]        cpu_be,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic [29:0]       dev_addr,
  output logic [31:0]       dev_wdata,
  output logic [NDEV-1:0]   dev_we,
  input  logic [32*NDEV-1:0] dev_rdata,
  input  logic [NDEV-1:0]   dev_irq,
  output logic [NDEV-1:0]   hw_int
);

  localparam logic [31:0] LBASE = BASE + NDEV * STRIDE;
  localparam logic [31:0] TOP   = LBASE + 32'd16;

  logic [NDEV-1:0] slot_hit;
  logic            local_hit;
  logic            in_range;
  logic            hole;
  logic            full_word;
  logic            access;
  logic [1:0]      lidx;
  logic            local_wr;
  logic            err_event;

  logic [NDEV-1:0] pend_q;
  logic [NDEV-1:0] irq_q;
  logic [NDEV-1:0] mask_q;
  logic [31:0]     err_addr_q;
  logic [7:0]      err_cnt_q;

  logic [NDEV-1:0] irq_rise;
  logic [NDEV-1:0] pend_w1c;
  logic [NDEV-1:0] pend_d;
  logic [NDEV-1:0] eff_pend;

  // Address decode
  always_comb begin
    slot_hit = '0;
    for (int unsigned k = 0; k < NDEV; k++) begin
      slot_hit[k] = (cpu_addr >= BASE + k * STRIDE) &&
                    (cpu_addr <  BASE + k * STRIDE + WIN_BYTES);
    end
  end

  assign local_hit = (cpu_addr >= LBASE) && (cpu_addr < TOP);
  assign in_range  = (cpu_addr >= BASE)  && (cpu_addr < TOP);
  assign hole      = in_range && !(|slot_hit) && !local_hit;
  assign full_word = (cpu_be == 4'b1111);
  assign access    = cpu_we | cpu_re;
  assign lidx      = 2'((cpu_addr - LBASE) >> 2);

  // A simultaneous load strobe is ignored: cpu_we alone decides store handling.
  assign local_wr  = cpu_we && local_hit && full_word;
  assign err_event = (access && hole) ||
                     (cpu_we && !full_word && ((|slot_hit) || local_hit));

  assign dev_addr  = cpu_addr[31:2];
  assign dev_wdata = cpu_wdata;
  assign dev_we    = (cpu_we && full_word && !reset) ? slot_hit : '0;

  // Interrupt pending logic
  assign irq_rise = IRQ_EDGE & dev_irq & ~irq_q;
  assign pend_w1c = (local_wr && lidx == 2'd0) ? cpu_wdata[NDEV-1:0] : '0;
  // A set arriving in the same cycle as its W1C wins because it is ORed after the clear.
  assign pend_d   = ((pend_q & ~pend_w1c) | irq_rise) & IRQ_EDGE;
  assign eff_pend = (pend_q & IRQ_EDGE) | (dev_irq & ~IRQ_EDGE);
  assign hw_int   = eff_pend & mask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      irq_q  <= '0;
      mask_q <= '1;
    end else begin
      pend_q <= pend_d;
      irq_q  <= dev_irq;
      if (local_wr && lidx == 2'd1) begin
        mask_q <= cpu_wdata[NDEV-1:0];
      end
    end
  end

  // Error logger
  always_ff @(posedge clk) begin
    if (reset) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else if (local_wr && lidx == 2'd3) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else if (err_event) begin
      if (err_cnt_q == 8'd0) begin
        err_addr_q <= cpu_addr;
      end
      if (err_cnt_q != 8'hff) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  // Read mux
  always_comb begin
    cpu_rdata = '0;
    for (int unsigned k = 0; k < NDEV; k++) begin
      if (slot_hit[k]) begin
        cpu_rdata = dev_rdata[32*k +: 32];
      end
    end
    if (local_hit) begin
      case (lidx)
        2'd0:    cpu_rdata = 32'(eff_pend);
        2'd1:    cpu_rdata = 32'(mask_q);
        2'd2:    cpu_rdata = err_addr_q;
        default: cpu_rdata = 32'(err_cnt_q);
      endcase
    end
  end

endmodule

// File: tb/tb_irq_io_bridge.sv
// Directed testbench for irq_io_bridge (NDEV=2, slot 1 edge-mode, slot 0 level-mode).
module tb_irq_io_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_we;
  logic        cpu_re;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic [29:0] dev_addr;
  logic [31:0] dev_wdata;
  logic [1:0]  dev_we;
  logic [63:0] dev_rdata;
  logic [1:0]  dev_irq;
  logic [1:0]  hw_int;

  int vectors = 0;
  int miscompares = 0;

  irq_io_bridge #(
    .NDEV(2),
    .BASE(32'h0000_7f00),
    .STRIDE(32'h10),
    .WIN_BYTES(12),
    .IRQ_EDGE(2'b10)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_we(dev_we),
    .dev_rdata(dev_rdata), .dev_irq(dev_irq), .hw_int(hw_int)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    cpu_addr = a; cpu_be = be; cpu_wdata = d; cpu_we = 1'b1; cpu_re = 1'b0;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d);
    cpu_addr = a; cpu_be = 4'hf; cpu_re = 1'b1; cpu_we = 1'b0;
    #1;
    d = cpu_rdata;
    tick();
    cpu_re = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; dev_irq = '0; dev_rdata = '0;
    cpu_addr = 32'h7f04; cpu_be = 4'hf; cpu_wdata = 32'h55; cpu_we = 1'b1; cpu_re = 1'b0;
    tick();
    vectors++;
    if (dev_we !== 2'b00) begin miscompares++; $display("FAIL reset_dev_we got=%b exp=00", dev_we); end
    tick();
    reset = 1'b0; cpu_we = 1'b0;
    load(32'h7f20, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_pend got=%h exp=0", d); end
    load(32'h7f24, d);
    vectors++;
    if (d !== 32'h3) begin miscompares++; $display("FAIL reset_mask got=%h exp=3", d); end
    load(32'h7f28, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_erraddr got=%h exp=0", d); end
    load(32'h7f2c, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_errcnt got=%h exp=0", d); end
    vectors++;
    if (hw_int !== 2'b00) begin miscompares++; $display("FAIL reset_hw_int got=%b exp=00", hw_int); end
  endtask

  task automatic test_dev_write();
    logic [31:0] a [4] = '{32'h7f04, 32'h7f08, 32'h7f18, 32'h7f0c};
    logic [1:0]  e [4] = '{2'b01, 2'b01, 2'b10, 2'b00};
    cpu_be = 4'hf; cpu_wdata = 32'h1234; cpu_we = 1'b1; cpu_addr = 32'h7f04;
    #1;
    vectors++;
    if (dev_addr !== 30'h1fc1) begin miscompares++; $display("FAIL dev_addr got=%h exp=1fc1", dev_addr); end
    vectors++;
    if (dev_wdata !== 32'h1234) begin miscompares++; $display("FAIL dev_wdata got=%h exp=1234", dev_wdata); end
    for (int i = 0; i < 4; i++) begin
      cpu_addr = a[i];
      #1;
      vectors++;
      if (dev_we !== e[i]) begin miscompares++; $display("FAIL dev_we[%h] got=%b exp=%b", a[i], dev_we, e[i]); end
    end
    cpu_we = 1'b0;
    // the write to the hole at 0x7f0c was held only combinationally; clear nothing yet
    store(32'h7f2c, 4'hf, 32'h0);
  endtask

  task automatic test_dev_read();
    logic [31:0] d;
    dev_rdata = {32'h0000_abcd, 32'h5555_5555};
    load(32'h7f14, d);
    vectors++;
    if (d !== 32'h0000_abcd) begin miscompares++; $display("FAIL read_slot1 got=%h exp=abcd", d); end
    load(32'h7f00, d);
    vectors++;
    if (d !== 32'h5555_5555) begin miscompares++; $display("FAIL read_slot0 got=%h exp=55555555", d); end
    load(32'h7ef0, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL read_below got=%h exp=0", d); end
    load(32'h7f30, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL read_top got=%h exp=0", d); end
    store(32'h7f30, 4'h1, 32'h0);
    load(32'h7f2c, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL no_err_outside got=%h exp=0", d); end
  endtask

  task automatic test_partial_err();
    logic [31:0] d;
    cpu_addr = 32'h7f00; cpu_be = 4'b0001; cpu_wdata = 32'hff; cpu_we = 1'b1;
    #1;
    vectors++;
    if (dev_we !== 2'b00) begin miscompares++; $display("FAIL partial_dev_we got=%b exp=00", dev_we); end
    tick();
    cpu_we = 1'b0;
    load(32'h7f2c, d);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL partial_cnt got=%h exp=1", d); end
    load(32'h7f28, d);
    vectors++;
    if (d !== 32'h7f00) begin miscompares++; $display("FAIL partial_addr got=%h exp=7f00", d); end
    load(32'h7f0c, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL hole_rdata got=%h exp=0", d); end
    load(32'h7f2c, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL hole_cnt got=%h exp=2", d); end
    load(32'h7f28, d);
    vectors++;
    if (d !== 32'h7f00) begin miscompares++; $display("FAIL hole_addr_kept got=%h exp=7f00", d); end
    store(32'h7f24, 4'b0011, 32'h0);
    load(32'h7f24, d);
    vectors++;
    if (d !== 32'h3) begin miscompares++; $display("FAIL partial_local_mask got=%h exp=3", d); end
    load(32'h7f2c, d);
    vectors++;
    if (d !== 32'h3) begin miscompares++; $display("FAIL partial_local_cnt got=%h exp=3", d); end
    store(32'h7f2c, 4'hf, 32'hdead_beef);
    load(32'h7f2c, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL clear_cnt got=%h exp=0", d); end
    load(32'h7f28, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL clear_addr got=%h exp=0", d); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] d;
    dev_irq = 2'b10;
    #1;
    vectors++;
    if (hw_int !== 2'b00) begin miscompares++; $display("FAIL edge_before got=%b exp=00", hw_int); end
    tick();
    dev_irq = 2'b00;
    vectors++;
    if (hw_int !== 2'b10) begin miscompares++; $display("FAIL edge_set got=%b exp=10", hw_int); end
    repeat (3) tick();
    vectors++;
    if (hw_int !== 2'b10) begin miscompares++; $display("FAIL edge_hold got=%b exp=10", hw_int); end
    load(32'h7f20, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL edge_pend got=%h exp=2", d); end
    dev_irq = 2'b10;
    tick();
    store(32'h7f20, 4'hf, 32'h2);
    vectors++;
    if (hw_int !== 2'b00) begin miscompares++; $display("FAIL edge_w1c got=%b exp=00", hw_int); end
    repeat (3) tick();
    vectors++;
    if (hw_int !== 2'b00) begin miscompares++; $display("FAIL edge_level_no_reset got=%b exp=00", hw_int); end
    dev_irq = 2'b00;
    tick();
    dev_irq = 2'b10;
    store(32'h7f20, 4'hf, 32'h2);
    vectors++;
    if (hw_int !== 2'b10) begin miscompares++; $display("FAIL set_wins got=%b exp=10", hw_int); end
    dev_irq = 2'b00;
    store(32'h7f20, 4'hf, 32'h2);
    vectors++;
    if (hw_int !== 2'b00) begin miscompares++; $display("FAIL edge_final_clear got=%b exp=00", hw_int); end
  endtask

  task automatic test_mask_level();
    logic [31:0] d;
    dev_irq = 2'b01;
    #1;
    vectors++;
    if (hw_int !== 2'b01) begin miscompares++; $display("FAIL level_pass got=%b exp=01", hw_int); end
    store(32'h7f24, 4'hf, 32'h0);
    vectors++;
    if (hw_int !== 2'b00) begin miscompares++; $display("FAIL level_masked got=%b exp=00", hw_int); end
    load(32'h7f20, d);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL level_pend got=%h exp=1", d); end
    store(32'h7f20, 4'hf, 32'h1);
    load(32'h7f20, d);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL level_ignores_w1c got=%h exp=1", d); end
    store(32'h7f24, 4'hf, 32'hffff_ffff);
    load(32'h7f24, d);
    vectors++;
    if (d !== 32'h3) begin miscompares++; $display("FAIL mask_upper_zero got=%h exp=3", d); end
    vectors++;
    if (hw_int !== 2'b01) begin miscompares++; $display("FAIL level_unmasked got=%b exp=01", hw_int); end
    dev_irq = 2'b00;
    #1;
    vectors++;
    if (hw_int !== 2'b00) begin miscompares++; $display("FAIL level_drop got=%b exp=00", hw_int); end
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    cpu_addr = 32'h7f1c; cpu_re = 1'b1;
    repeat (300) tick();
    cpu_re = 1'b0;
    load(32'h7f2c, d);
    vectors++;
    if (d !== 32'hff) begin miscompares++; $display("FAIL sat_cnt got=%h exp=ff", d); end
    load(32'h7f28, d);
    vectors++;
    if (d !== 32'h7f1c) begin miscompares++; $display("FAIL sat_addr got=%h exp=7f1c", d); end
    store(32'h7f2c, 4'hf, 32'h1234_5678);
    load(32'h7f2c, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL sat_clear_cnt got=%h exp=0", d); end
    load(32'h7f28, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL sat_clear_addr got=%h exp=0", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    cpu_addr = 32'h7f10; cpu_be = 4'hf; cpu_wdata = 32'h77; cpu_we = 1'b1; cpu_re = 1'b1;
    #1;
    vectors++;
    if (dev_we !== 2'b10) begin miscompares++; $display("FAIL we_re_store got=%b exp=10", dev_we); end
    tick();
    cpu_addr = 32'h7f24; cpu_wdata = 32'h2; cpu_re = 1'b0;
    tick();
    cpu_addr = 32'h7f0c; cpu_we = 1'b0; cpu_re = 1'b1;
    tick();
    cpu_re = 1'b0;
    load(32'h7f24, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL b2b_mask got=%h exp=2", d); end
    load(32'h7f2c, d);
    vectors++;
    if (d !== 32'h1) begin miscompares++; $display("FAIL b2b_cnt got=%h exp=1", d); end
    store(32'h7f24, 4'hf, 32'h3);
    store(32'h7f2c, 4'hf, 32'h0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    dev_irq = 2'b10;
    tick();
    dev_irq = 2'b00;
    repeat (5) load(32'h7f0c, d);
    store(32'h7f24, 4'hf, 32'h0);
    load(32'h7f20, d);
    vectors++;
    if (d !== 32'h2) begin miscompares++; $display("FAIL pre_reset_pend got=%h exp=2", d); end
    load(32'h7f2c, d);
    vectors++;
    if (d !== 32'h5) begin miscompares++; $display("FAIL pre_reset_cnt got=%h exp=5", d); end
    reset = 1'b1;
    cpu_addr = 32'h7f04; cpu_be = 4'hf; cpu_wdata = 32'h99; cpu_we = 1'b1;
    #1;
    vectors++;
    if (dev_we !== 2'b00) begin miscompares++; $display("FAIL mid_reset_dev_we got=%b exp=00", dev_we); end
    tick();
    reset = 1'b0; cpu_we = 1'b0;
    load(32'h7f20, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL post_reset_pend got=%h exp=0", d); end
    load(32'h7f24, d);
    vectors++;
    if (d !== 32'h3) begin miscompares++; $display("FAIL post_reset_mask got=%h exp=3", d); end
    load(32'h7f2c, d);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL post_reset_cnt got=%h exp=0", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    cpu_addr = '0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_be = 4'hf; cpu_wdata = '0;
    dev_rdata = '0; dev_irq = '0; reset = 1'b1;
    #1;
    test_reset();
    test_dev_write();
    test_dev_read();
    test_partial_err();
    test_edge_irq();
    test_mask_level();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
